// File: rtl/qcl_event_blink_pkg.sv
// Shared types and helpers for the event blinker and its cycle timer.
// Pulls in nothing; imported by qcl_event_blink.
package qcl_event_blink_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOn   = 2'd1,
    StOff  = 2'd2
  } state_e;

  // Width needed to hold the larger of the two load values; never below 1 bit.
  function automatic int unsigned timer_width(input int unsigned on_c,
                                              input int unsigned off_c);
    int unsigned m;
    m = (on_c > off_c) ? on_c : off_c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/qcl_cycle_timer.sv
// Loadable down counter that stops at zero; zero_o flags the terminal count.
module qcl_cycle_timer #(
  parameter int unsigned width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  input  logic               en_i,
  output logic               zero_o
);

  logic [width_p-1:0] r_count;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_count <= '0;
    end else if (load_i) begin
      r_count <= load_val_i;
    end else if (en_i && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero_o = (r_count == '0);

endmodule

// File: rtl/qcl_event_blink.sv
// Stretches single-cycle events into visible pulses with a guaranteed low gap, queueing
// events that arrive mid-pulse. QCL_EVENT_BLINK_OVERFLOW_EN adds a sticky overflow_o flag.
module qcl_event_blink
  import qcl_event_blink_pkg::*;
#(
  parameter int unsigned on_cycles_p   = 2**21,
  parameter int unsigned off_cycles_p  = 2**21,
  parameter int unsigned pending_max_p = 15
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic                                 v_i,
  output logic                                 o,
  output logic                                 busy_o,
  output logic [$clog2(pending_max_p+1)-1:0]   pending_o
`ifdef QCL_EVENT_BLINK_OVERFLOW_EN
  ,
  output logic                                 overflow_o
`endif
);

  localparam int unsigned TimerW = timer_width(on_cycles_p, off_cycles_p);
  localparam int unsigned PendW  = $clog2(pending_max_p + 1);
  localparam logic [TimerW-1:0] OnLoad  = TimerW'(on_cycles_p - 1);
  localparam logic [TimerW-1:0] OffLoad = TimerW'(off_cycles_p - 1);
  localparam logic [PendW-1:0]  PendMax = PendW'(pending_max_p);

  state_e            r_state;
  logic              r_o;
  logic              r_busy;
  logic [PendW-1:0]  r_pending;
  logic              w_zero;
  logic              w_avail;
  logic              w_consume;
  logic              w_load;
  logic [TimerW-1:0] w_load_val;

  // An event can start a pulse from IDLE or on the last OFF cycle.
  assign w_avail    = v_i | (r_pending != '0);
  assign w_consume  = w_avail & ((r_state == StIdle) | ((r_state == StOff) & w_zero));
  assign w_load     = w_consume | ((r_state == StOn) & w_zero);
  assign w_load_val = w_consume ? OnLoad : OffLoad;

  qcl_cycle_timer #(
    .width_p (TimerW)
  ) u_timer (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .load_i     (w_load),
    .load_val_i (w_load_val),
    .en_i       (r_busy),
    .zero_o     (w_zero)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= StIdle;
      r_o     <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_consume) begin
            r_state <= StOn;
            r_o     <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        StOn: begin
          if (w_zero) begin
            r_state <= StOff;
            r_o     <= 1'b0;
          end
        end
        StOff: begin
          if (w_zero) begin
            if (w_consume) begin
              r_state <= StOn;
              r_o     <= 1'b1;
            end else begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_o     <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Pending events go first, so consume+v_i leaves the count unchanged.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_pending <= '0;
    end else if (w_consume && !v_i) begin
      r_pending <= r_pending - 1'b1;
    end else if (v_i && !w_consume && (r_pending != PendMax)) begin
      r_pending <= r_pending + 1'b1;
    end
  end

`ifdef QCL_EVENT_BLINK_OVERFLOW_EN
  logic w_drop;
  logic r_overflow;

  assign w_drop = v_i & ~w_consume & (r_pending == PendMax);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow_o = r_overflow;
`endif

  assign o         = r_o;
  assign busy_o    = r_busy;
  assign pending_o = r_pending;

endmodule

// File: tb/tb_qcl_event_blink.sv
// Self-checking bench for qcl_event_blink against a timeline model of pulses and queue.
module tb_qcl_event_blink;

  localparam int unsigned On   = 4;
  localparam int unsigned Off  = 3;
  localparam int unsigned PMax = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       v = 1'b0;
  logic       o;
  logic       busy;
  logic [1:0] pending;
  logic       ovf;
  logic [4:0] obs;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int m_lc   = -1000;  // cycle in which the most recent pulse was started
  int m_pend = 0;
  bit m_ovf  = 1'b0;

  always #5 clk = ~clk;

  qcl_event_blink #(
    .on_cycles_p   (On),
    .off_cycles_p  (Off),
    .pending_max_p (PMax)
  ) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .v_i        (v),
    .o          (o),
    .busy_o     (busy),
    .pending_o  (pending)
`ifdef QCL_EVENT_BLINK_OVERFLOW_EN
    ,
    .overflow_o (ovf)
`endif
  );

`ifndef QCL_EVENT_BLINK_OVERFLOW_EN
  assign ovf = 1'b0;
`endif

  assign obs = {o, busy, pending, ovf};

  function automatic logic [4:0] expect_now();
    logic o_e, b_e, f_e;
    o_e = (cyc >= m_lc + 1) && (cyc <= m_lc + int'(On));
    b_e = (cyc >= m_lc + 1) && (cyc <= m_lc + int'(On) + int'(Off));
`ifdef QCL_EVENT_BLINK_OVERFLOW_EN
    f_e = m_ovf;
`else
    f_e = 1'b0;
`endif
    return {o_e, b_e, 2'(m_pend), f_e};
  endfunction

  task automatic model_reset();
    m_lc   = -1000;
    m_pend = 0;
    m_ovf  = 1'b0;
  endtask

  // Applies v for the current cycle, advances model and clock, lands 1 time unit after edge.
  task automatic tick(input logic vin);
    bit cons;
    v = vin;
    cons = (cyc >= m_lc + int'(On) + int'(Off)) && (vin || (m_pend > 0));
    if (cons) m_lc = cyc;
    if (cons && !vin) m_pend--;
    else if (vin && !cons) begin
      if (m_pend == int'(PMax)) m_ovf = 1'b1;
      else m_pend++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    logic [4:0] e;
    reset_n = 1'b0;
    v = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_held got=%b want=%b", obs, 5'b0);
    end
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      e = expect_now();
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got=%b want=%b", cyc, obs, e);
      end
      tick(1'b0);
    end
  endtask

  task automatic test_single();
    logic [4:0] e;
    for (int i = 0; i < 16; i++) begin
      e = expect_now();
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL single cyc=%0d got=%b want=%b", cyc, obs, e);
      end
      tick(i == 2);
    end
  endtask

  task automatic test_queue();
    logic [4:0] e;
    for (int i = 0; i < 30; i++) begin
      e = expect_now();
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL queue cyc=%0d got=%b want=%b", cyc, obs, e);
      end
      tick(i >= 2 && i <= 4);
    end
  endtask

  task automatic test_overflow();
    logic [4:0] e;
    for (int i = 0; i < 32; i++) begin
      e = expect_now();
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL overflow cyc=%0d got=%b want=%b", cyc, obs, e);
      end
      tick(i >= 2 && i <= 5);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] e;
    // Second event lands on the last OFF cycle of the first pulse.
    for (int i = 0; i < 22; i++) begin
      e = expect_now();
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL back_to_back cyc=%0d got=%b want=%b", cyc, obs, e);
      end
      tick(i == 2 || i == int'(2 + On + Off));
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] e;
    for (int i = 0; i < 4; i++) tick(i < 3);
    e = expect_now();
    n_cmp++;
    if (obs !== e || e[4] !== 1'b1 || e[2:1] !== 2'd2) begin
      n_fail++;
      $display("FAIL pre_async_reset got=%b want=%b", obs, e);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 5'b0) begin
      n_fail++;
      $display("FAIL async_reset got=%b want=%b", obs, 5'b0);
    end
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      e = expect_now();
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL after_reset cyc=%0d got=%b want=%b", cyc, obs, e);
      end
      tick(i == 8);
    end
  endtask

  task automatic test_random();
    logic [4:0] e;
    for (int i = 0; i < 600; i++) begin
      e = expect_now();
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%b want=%b", cyc, obs, e);
      end
      tick($urandom_range(0, 9) < 3);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_queue();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
